// File: rtl/reg_file_n.sv
// Parametrised register file: one write port, two combinational read ports,
// an increment/decrement unit and a sequenced clear that walks every register.
module reg_file_n #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int SEL_W  = 8,
  parameter int BYPASS = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [SEL_W-1:0]        wr_sel,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    idu_inc,
  input  logic                    idu_dec,
  input  logic [SEL_W-1:0]        idu_sel,
  output logic                    idu_carry,
  input  logic                    rd_a_en,
  input  logic [SEL_W-1:0]        rd_a_sel,
  output logic [DATA_W-1:0]       rd_a_data,
  input  logic                    rd_b_en,
  input  logic [SEL_W-1:0]        rd_b_sel,
  output logic [DATA_W-1:0]       rd_b_data,
  input  logic                    clr_start,
  output logic                    busy,
  output logic [NREGS*DATA_W-1:0] regs_flat
);

  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_CLEAR = 1'b1;

  logic [DATA_W-1:0] regs_reg [NREGS];
  logic              state_reg;
  logic [IDX_W-1:0]  clr_idx_reg;
  logic              idu_carry_reg;

  // Valid only when the bits above the index are zero and the index exists.
  function automatic logic sel_valid(input logic [SEL_W-1:0] sel);
    logic [SEL_W-1:0] upper;
    upper = sel >> IDX_W;
    return (upper == '0) && (int'(sel[IDX_W-1:0]) < NREGS);
  endfunction

  logic [IDX_W-1:0] wr_idx, idu_idx, rd_a_idx, rd_b_idx;
  assign wr_idx   = wr_sel[IDX_W-1:0];
  assign idu_idx  = idu_sel[IDX_W-1:0];
  assign rd_a_idx = rd_a_sel[IDX_W-1:0];
  assign rd_b_idx = rd_b_sel[IDX_W-1:0];

  assign busy = (state_reg == STATE_CLEAR);

  logic wr_ok;
  logic idu_ok;
  assign wr_ok  = wr_en && !busy && sel_valid(wr_sel);
  // A write to the same register wins; the inc/dec is dropped entirely.
  assign idu_ok = (idu_inc ^ idu_dec) && !busy && sel_valid(idu_sel)
                  && !(wr_ok && (wr_idx == idu_idx));

  logic [DATA_W-1:0] idu_cur;
  logic [DATA_W:0]   idu_sum;
  always_comb begin
    idu_cur = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (idu_idx == IDX_W'(i)) idu_cur = regs_reg[i];
    end
    if (idu_inc) idu_sum = {1'b0, idu_cur} + {{DATA_W{1'b0}}, 1'b1};
    else         idu_sum = {1'b0, idu_cur} - {{DATA_W{1'b0}}, 1'b1};
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (reset)
          regs_reg[gi] <= '0;
        else if (busy && (clr_idx_reg == IDX_W'(gi)))
          regs_reg[gi] <= '0;
        else if (wr_ok && (wr_idx == IDX_W'(gi)))
          regs_reg[gi] <= wr_data;
        else if (idu_ok && (idu_idx == IDX_W'(gi)))
          regs_reg[gi] <= idu_sum[DATA_W-1:0];
      end
      assign regs_flat[gi*DATA_W +: DATA_W] = regs_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)
      idu_carry_reg <= 1'b0;
    else if (idu_ok)
      idu_carry_reg <= idu_sum[DATA_W];
  end
  assign idu_carry = idu_carry_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= STATE_IDLE;
      clr_idx_reg <= '0;
    end else begin
      case (state_reg)
        STATE_IDLE: begin
          if (clr_start) begin
            state_reg   <= STATE_CLEAR;
            clr_idx_reg <= '0;
          end
        end
        default: begin
          if (clr_idx_reg == IDX_W'(NREGS - 1)) begin
            state_reg   <= STATE_IDLE;
            clr_idx_reg <= '0;
          end else begin
            clr_idx_reg <= clr_idx_reg + 1'b1;
          end
        end
      endcase
    end
  end

  // Forwarding only sees accepted writes, so it is naturally off while busy.
  always_comb begin
    rd_a_data = '0;
    if (rd_a_en && sel_valid(rd_a_sel)) begin
      for (int i = 0; i < NREGS; i++) begin
        if (rd_a_idx == IDX_W'(i)) rd_a_data = regs_reg[i];
      end
      if ((BYPASS != 0) && wr_ok && (wr_sel == rd_a_sel)) rd_a_data = wr_data;
    end
  end

  always_comb begin
    rd_b_data = '0;
    if (rd_b_en && sel_valid(rd_b_sel)) begin
      for (int i = 0; i < NREGS; i++) begin
        if (rd_b_idx == IDX_W'(i)) rd_b_data = regs_reg[i];
      end
      if ((BYPASS != 0) && wr_ok && (wr_sel == rd_b_sel)) rd_b_data = wr_data;
    end
  end

endmodule

// File: tb/tb_reg_file_n.sv
// Directed bench for reg_file_n: a forwarding instance and a non-forwarding
// instance share every input; each scenario task checks its own results.
module tb_reg_file_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [7:0]  wr_sel;
  logic [7:0]  wr_data;
  logic        idu_inc, idu_dec;
  logic [7:0]  idu_sel;
  logic        rd_a_en, rd_b_en;
  logic [7:0]  rd_a_sel, rd_b_sel;
  logic        clr_start;

  logic        idu_carry, busy;
  logic [7:0]  rd_a_data, rd_b_data;
  logic [31:0] regs_flat;

  logic        nb_idu_carry, nb_busy;
  logic [7:0]  nb_rd_a_data, nb_rd_b_data;
  logic [31:0] nb_regs_flat;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_file_n #(.DATA_W(8), .NREGS(4), .SEL_W(8), .BYPASS(1)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .idu_inc(idu_inc), .idu_dec(idu_dec), .idu_sel(idu_sel), .idu_carry(idu_carry),
    .rd_a_en(rd_a_en), .rd_a_sel(rd_a_sel), .rd_a_data(rd_a_data),
    .rd_b_en(rd_b_en), .rd_b_sel(rd_b_sel), .rd_b_data(rd_b_data),
    .clr_start(clr_start), .busy(busy), .regs_flat(regs_flat)
  );

  reg_file_n #(.DATA_W(8), .NREGS(4), .SEL_W(8), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .idu_inc(idu_inc), .idu_dec(idu_dec), .idu_sel(idu_sel), .idu_carry(nb_idu_carry),
    .rd_a_en(rd_a_en), .rd_a_sel(rd_a_sel), .rd_a_data(nb_rd_a_data),
    .rd_b_en(rd_b_en), .rd_b_sel(rd_b_sel), .rd_b_data(nb_rd_b_data),
    .clr_start(clr_start), .busy(nb_busy), .regs_flat(nb_regs_flat)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    wr_en = 1'b0; wr_sel = 8'h00; wr_data = 8'h00;
    idu_inc = 1'b0; idu_dec = 1'b0; idu_sel = 8'h00;
    clr_start = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] sel, input logic [7:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    rd_a_en = 1'b1; rd_a_sel = 8'h00; rd_b_en = 1'b1; rd_b_sel = 8'h03;
    tick(); tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (regs_flat !== 32'h0) begin n_fail++; $display("FAIL reset_flat: got %h expected %h", regs_flat, 32'h0); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (idu_carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got %b expected 0", idu_carry); end
    n_cmp++; if (rd_a_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_a: got %h expected 00", rd_a_data); end
    $display("reset: flat=%h busy=%b carry=%b", regs_flat, busy, idu_carry);
  endtask

  task automatic test_write_read;
    do_write(8'h01, 8'hA5);
    do_write(8'h02, 8'h3C);
    rd_a_en = 1'b1; rd_a_sel = 8'h01; rd_b_en = 1'b1; rd_b_sel = 8'h02;
    #1;
    n_cmp++; if (rd_a_data !== 8'hA5) begin n_fail++; $display("FAIL wr_rd_a: got %h expected a5", rd_a_data); end
    n_cmp++; if (rd_b_data !== 8'h3C) begin n_fail++; $display("FAIL wr_rd_b: got %h expected 3c", rd_b_data); end
    n_cmp++; if (regs_flat !== 32'h003CA500) begin n_fail++; $display("FAIL wr_flat: got %h expected 003ca500", regs_flat); end
    rd_b_sel = 8'h01;
    #1;
    n_cmp++; if (rd_b_data !== 8'hA5) begin n_fail++; $display("FAIL rd_same_reg: got %h expected a5", rd_b_data); end
    rd_b_en = 1'b0;
    #1;
    n_cmp++; if (rd_b_data !== 8'h00) begin n_fail++; $display("FAIL rd_disabled: got %h expected 00", rd_b_data); end
    $display("write/read: a=%h flat=%h", rd_a_data, regs_flat);
  endtask

  task automatic test_bypass;
    do_write(8'h00, 8'h11);
    rd_a_en = 1'b1; rd_a_sel = 8'h00;
    wr_en = 1'b1; wr_sel = 8'h00; wr_data = 8'h77;
    #1;
    n_cmp++; if (rd_a_data !== 8'h77) begin n_fail++; $display("FAIL bypass_on: got %h expected 77", rd_a_data); end
    n_cmp++; if (nb_rd_a_data !== 8'h11) begin n_fail++; $display("FAIL bypass_off_same: got %h expected 11", nb_rd_a_data); end
    n_cmp++; if (regs_flat[7:0] !== 8'h11) begin n_fail++; $display("FAIL flat_not_bypassed: got %h expected 11", regs_flat[7:0]); end
    tick();
    wr_en = 1'b0;
    #1;
    n_cmp++; if (nb_rd_a_data !== 8'h77) begin n_fail++; $display("FAIL bypass_off_next: got %h expected 77", nb_rd_a_data); end
    $display("bypass: on=%h off=%h", rd_a_data, nb_rd_a_data);
  endtask

  task automatic test_idu;
    do_write(8'h03, 8'hFF);
    idu_sel = 8'h03;
    idu_inc = 1'b1; tick(); idu_inc = 1'b0;
    n_cmp++; if (regs_flat[31:24] !== 8'h00) begin n_fail++; $display("FAIL inc_wrap_val: got %h expected 00", regs_flat[31:24]); end
    n_cmp++; if (idu_carry !== 1'b1) begin n_fail++; $display("FAIL inc_wrap_carry: got %b expected 1", idu_carry); end
    idu_inc = 1'b1; idu_dec = 1'b1; tick(); idu_inc = 1'b0; idu_dec = 1'b0;
    n_cmp++; if (regs_flat[31:24] !== 8'h00) begin n_fail++; $display("FAIL both_noop_val: got %h expected 00", regs_flat[31:24]); end
    n_cmp++; if (idu_carry !== 1'b1) begin n_fail++; $display("FAIL both_noop_carry: got %b expected 1", idu_carry); end
    idu_dec = 1'b1; tick(); idu_dec = 1'b0;
    n_cmp++; if (regs_flat[31:24] !== 8'hFF) begin n_fail++; $display("FAIL dec_wrap_val: got %h expected ff", regs_flat[31:24]); end
    n_cmp++; if (idu_carry !== 1'b1) begin n_fail++; $display("FAIL dec_wrap_carry: got %b expected 1", idu_carry); end
    idu_dec = 1'b1; tick(); idu_dec = 1'b0;
    n_cmp++; if (regs_flat[31:24] !== 8'hFE) begin n_fail++; $display("FAIL dec_val: got %h expected fe", regs_flat[31:24]); end
    n_cmp++; if (idu_carry !== 1'b0) begin n_fail++; $display("FAIL dec_carry: got %b expected 0", idu_carry); end
    $display("idu: reg3=%h carry=%b", regs_flat[31:24], idu_carry);
  endtask

  task automatic test_write_idu_collide;
    do_write(8'h01, 8'h05);
    // Set the carry so a discarded inc/dec can be seen leaving it alone.
    do_write(8'h00, 8'hFF);
    idu_sel = 8'h00; idu_inc = 1'b1; tick(); idu_inc = 1'b0;
    wr_en = 1'b1; wr_sel = 8'h02; wr_data = 8'h40;
    idu_inc = 1'b1; idu_sel = 8'h02;
    tick();
    n_cmp++; if (regs_flat[23:16] !== 8'h40) begin n_fail++; $display("FAIL collide_same_val: got %h expected 40", regs_flat[23:16]); end
    n_cmp++; if (idu_carry !== 1'b1) begin n_fail++; $display("FAIL collide_same_carry: got %b expected 1", idu_carry); end
    idu_sel = 8'h01;
    tick();
    wr_en = 1'b0; idu_inc = 1'b0;
    n_cmp++; if (regs_flat[23:16] !== 8'h40) begin n_fail++; $display("FAIL collide_diff_wr: got %h expected 40", regs_flat[23:16]); end
    n_cmp++; if (regs_flat[15:8] !== 8'h06) begin n_fail++; $display("FAIL collide_diff_inc: got %h expected 06", regs_flat[15:8]); end
    n_cmp++; if (idu_carry !== 1'b0) begin n_fail++; $display("FAIL collide_diff_carry: got %b expected 0", idu_carry); end
    $display("collide: flat=%h carry=%b", regs_flat, idu_carry);
  endtask

  task automatic test_clear;
    logic [31:0] exp_tbl [4];
    exp_tbl[0] = 32'h44332211;
    exp_tbl[1] = 32'h44332200;
    exp_tbl[2] = 32'h44330000;
    exp_tbl[3] = 32'h44000000;
    do_write(8'h00, 8'h11);
    do_write(8'h01, 8'h22);
    do_write(8'h02, 8'h33);
    // Write issued alongside clr_start is still accepted.
    wr_en = 1'b1; wr_sel = 8'h03; wr_data = 8'h44; clr_start = 1'b1;
    tick();
    wr_en = 1'b0; clr_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) begin
        wr_en = 1'b1; wr_sel = 8'h03; wr_data = 8'h99;
        rd_a_en = 1'b1; rd_a_sel = 8'h03;
        #1;
        n_cmp++; if (rd_a_data !== 8'h44) begin n_fail++; $display("FAIL clear_read_old: got %h expected 44", rd_a_data); end
      end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clear_busy c%0d: got %b expected 1", c, busy); end
      n_cmp++; if (regs_flat !== exp_tbl[c]) begin n_fail++; $display("FAIL clear_flat c%0d: got %h expected %h", c, regs_flat, exp_tbl[c]); end
      $display("clear cycle %0d: busy=%b flat=%h", c, busy, regs_flat);
      tick();
      wr_en = 1'b0;
    end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_done_busy: got %b expected 0", busy); end
    n_cmp++; if (regs_flat !== 32'h0) begin n_fail++; $display("FAIL clear_done_flat: got %h expected 0", regs_flat); end
  endtask

  task automatic test_mid_clear_reset;
    do_write(8'h00, 8'h0A);
    do_write(8'h02, 8'h0C);
    do_write(8'h03, 8'h0D);
    clr_start = 1'b1; tick(); clr_start = 1'b0;
    tick(); tick();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midclr_busy_before: got %b expected 1", busy); end
    reset = 1'b1; tick(); reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midclr_busy_after: got %b expected 0", busy); end
    n_cmp++; if (regs_flat !== 32'h0) begin n_fail++; $display("FAIL midclr_flat: got %h expected 0", regs_flat); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midclr_stays_idle: got %b expected 0", busy); end
    $display("mid-clear reset: busy=%b flat=%h", busy, regs_flat);
  endtask

  task automatic test_invalid_sel;
    do_write(8'h00, 8'hFF);
    idu_sel = 8'h00; idu_inc = 1'b1; tick(); idu_inc = 1'b0;
    do_write(8'h04, 8'hEE);
    do_write(8'h10, 8'hEE);
    idu_sel = 8'h04; idu_dec = 1'b1; tick(); idu_dec = 1'b0;
    n_cmp++; if (regs_flat !== 32'h0) begin n_fail++; $display("FAIL invalid_wr_idu_flat: got %h expected 0", regs_flat); end
    n_cmp++; if (idu_carry !== 1'b1) begin n_fail++; $display("FAIL invalid_idu_carry: got %b expected 1", idu_carry); end
    do_write(8'h00, 8'h5A);
    rd_a_en = 1'b1; rd_a_sel = 8'h10; rd_b_en = 1'b1; rd_b_sel = 8'h04;
    #1;
    n_cmp++; if (rd_a_data !== 8'h00) begin n_fail++; $display("FAIL invalid_rd_10: got %h expected 00", rd_a_data); end
    n_cmp++; if (rd_b_data !== 8'h00) begin n_fail++; $display("FAIL invalid_rd_04: got %h expected 00", rd_b_data); end
    $display("invalid sel: flat=%h rd_a=%h rd_b=%h", regs_flat, rd_a_data, rd_b_data);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    rd_a_en = 1'b0; rd_a_sel = 8'h00; rd_b_en = 1'b0; rd_b_sel = 8'h00;
    test_reset();
    test_write_read();
    test_bypass();
    test_idu();
    test_write_idu_collide();
    test_clear();
    test_mid_clear_reset();
    test_invalid_sel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_n.md
Name: reg_file_n

Overview:
- Parametrised successor to the fixed four-register 8-bit register file: N registers of DATA_W bits, one write port, two independent read ports, an increment/decrement unit and a multi-cycle sequenced clear.
- Sits between the control unit and the ALU. It feeds both ALU operands in one cycle and serves as the counter/stack-pointer store.
- All register contents are also exported as a flat tap bus for the debug display.

Parameters:
- DATA_W, 8, register and data-bus width in bits (>=2).
- NREGS, 4, number of registers (2..16).
- SEL_W, 8, width of every select bus; only the low $clog2(NREGS) bits index a register, the upper bits must be zero.
- BYPASS, 1, 1 = write-to-read forwarding in the same cycle; 0 = reads return the stored value.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  write enable.
- wr_sel  in  SEL_W  write register select.
- wr_data  in  DATA_W  write data.
- idu_inc  in  1  increment register idu_sel.
- idu_dec  in  1  decrement register idu_sel.
- idu_sel  in  SEL_W  inc/dec register select.
- idu_carry  out  1  registered carry/borrow of the last accepted inc/dec.
- rd_a_en  in  1  read port A enable.
- rd_a_sel  in  SEL_W  read port A select.
- rd_a_data  out  DATA_W  read port A data (combinational).
- rd_b_en  in  1  read port B enable.
- rd_b_sel  in  SEL_W  read port B select.
- rd_b_data  out  DATA_W  read port B data (combinational).
- clr_start  in  1  start sequenced clear.
- busy  out  1  high while clear is in progress.
- regs_flat  out  NREGS*DATA_W  register i at bits [i*DATA_W +: DATA_W].

Behaviour:
- Reset:
  - Every register = 0, idu_carry = 0, busy = 0, FSM = IDLE, clear index = 0.
  - Reset overrides every other input in the same cycle, including while a clear is in progress.
- Select validity: a select is valid iff the upper SEL_W bits are 0 and the index is < NREGS.
  - An invalid write or inc/dec select has no effect; idu_carry is unchanged.
  - An invalid read select returns 0.
- Reads (combinational):
  - rd_x_en = 0 -> rd_x_data = 0.
  - Otherwise rd_x_data = reg[rd_x_sel].
  - Both ports may read the same register.
- Write: when accepted, reg[wr_sel] <= wr_data at the rising edge; latency 1 cycle.
- Inc/dec:
  - Accepted when exactly one of idu_inc/idu_dec is high.
  - reg <= reg +/- 1 modulo 2^DATA_W.
  - idu_carry <= 1 on wrap: inc from all-ones, or dec from 0; otherwise idu_carry <= 0.
  - idu_inc and idu_dec both high -> no-op; idu_carry is unchanged.
- Simultaneous write and inc/dec:
  - Same register -> the write wins; the inc/dec is discarded and idu_carry is unchanged.
  - Different registers -> both take effect in the same cycle.
- Forwarding (BYPASS=1): if a write is accepted this cycle and rd_x_sel == wr_sel (valid, rd_x_en = 1), rd_x_data = wr_data.
  - Inc/dec results are never forwarded.
  - With BYPASS=0 the new value is visible the cycle after the edge.
- Clear FSM, states IDLE and CLEAR:
  - IDLE: clr_start = 1 -> CLEAR, index = 0, busy = 1 from the next cycle.
  - CLEAR: each cycle reg[index] <= 0 and index increments. After clearing index NREGS-1 -> IDLE, busy = 0. The sequence takes exactly NREGS cycles.
  - While busy, wr_en, idu_inc, idu_dec and clr_start are ignored. Reads stay live and return the current (partially cleared) contents.
  - While busy, forwarding is inactive because no write is accepted.
  - A write or inc/dec issued in the same cycle as clr_start (FSM in IDLE) is still accepted.
- Priority: reset > clear sequencing > write > inc/dec.
- regs_flat always reflects the stored values; it is never bypassed.

Test Plan:
- Reset, then write 0xA5 to reg1 and 0x3C to reg2; read A = reg1, read B = reg2 in the next cycle -> A = 0xA5, B = 0x3C; regs_flat = 0x003CA500.
- BYPASS=1: reg0 = 0x11; in one cycle wr_en = 1, reg0 <- 0x77, rd_a_sel = 0 -> rd_a_data = 0x77 in that cycle. Repeat with BYPASS=0 -> 0x11 in that cycle, 0x77 in the next.
- reg3 = 0xFF, idu_inc on reg3 -> reg3 = 0x00, idu_carry = 1. Then idu_dec -> reg3 = 0xFF, idu_carry = 1. Then idu_dec -> reg3 = 0xFE, idu_carry = 0.
- Same cycle: write 0x40 to reg2 and inc reg2 -> reg2 = 0x40. Same cycle: write 0x40 to reg2 and inc reg1 (= 5) -> reg2 = 0x40, reg1 = 6.
- Load all four registers with non-zero values, pulse clr_start -> busy high for exactly 4 cycles and the registers zero in order 0,1,2,3. A write to reg3 during busy is ignored; a read of reg3 at busy cycle 2 returns its old value.
- Mid-clear reset at busy cycle 2 -> next cycle busy = 0 and all registers = 0. Write to select 4 (invalid) -> no change; read select 0x10 -> 0.
